// File: rtl/ysyx_23060221_ifu.sv
// Instruction fetch unit for the serial multi-cycle core.
//
// Takes one pc from write-back over a valid/ready handshake. It then issues a
// single 32-bit read on an AXI4-Lite-style read channel and hands the
// instruction, its pc and a fault code to decode over a second valid/ready
// handshake. Only one fetch is in flight at a time.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   pc_i, wbu_valid_i  next pc offered by write-back; ifu_ready_o accepts it
//   araddr_o, arvalid_o, arready_i             read address channel
//   rdata_i, rresp_i, rvalid_i, rready_o       read data channel
//   inst_o, inst_pc_o, fault_o, ifu_valid_o    result towards decode
//   idu_ready_i       decode accepts the result
//   fetch_cnt_o       number of instructions delivered to decode
//
// Fault codes: 00 none, 01 bus error, 10 misaligned pc, 11 read timeout.
// A misaligned pc or a timeout delivers FAULT_INST (ebreak) as the instruction.
// A bus error still delivers rdata.
module ysyx_23060221_ifu #(
  parameter int unsigned TIMEOUT    = 255,          // RESP cycles before timeout, 1..255
  parameter logic [31:0] FAULT_INST = 32'h00100073  // ebreak
) (
  input  logic        clk,
  input  logic        rst,
  // write-back side
  input  logic [31:0] pc_i,
  input  logic        wbu_valid_i,
  output logic        ifu_ready_o,
  // read address channel
  output logic [31:0] araddr_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  // read data channel
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rvalid_i,
  output logic        rready_o,
  // decode side
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic [1:0]  fault_o,
  output logic        ifu_valid_o,
  input  logic        idu_ready_i,
  // statistics
  output logic [31:0] fetch_cnt_o
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp,
    StHold
  } state_e;

  localparam logic [1:0] FaultNone     = 2'b00;
  localparam logic [1:0] FaultBus      = 2'b01;
  localparam logic [1:0] FaultMisalign = 2'b10;
  localparam logic [1:0] FaultTimeout  = 2'b11;

  // The last RESP cycle before giving up is the one where the counter shows TIMEOUT-1.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        ifu_ready_q, ifu_ready_d;
  logic        ifu_valid_q, ifu_valid_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic [31:0] araddr_q, araddr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [1:0]  fault_q, fault_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [7:0]  cnt_q, cnt_d;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = wbu_valid_i & ifu_ready_q;
  assign out_xfer = ifu_valid_q & idu_ready_i;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-value logic for every register.
  always_comb begin
    state_d     = state_q;
    ifu_ready_d = ifu_ready_q;
    ifu_valid_d = ifu_valid_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    araddr_d    = araddr_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    fault_d     = fault_q;
    fetch_cnt_d = fetch_cnt_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      StIdle: begin
        // Bus inputs are deliberately ignored here, so a stale beat from an
        // access that reset aborted has no effect.
        if (in_xfer) begin
          inst_pc_d   = pc_i;
          ifu_ready_d = 1'b0;
          if (pc_i[1:0] != 2'b00) begin
            inst_d      = FAULT_INST;
            fault_d     = FaultMisalign;
            ifu_valid_d = 1'b1;
            state_d     = StHold;
          end else begin
            araddr_d  = pc_i;
            arvalid_d = 1'b1;
            state_d   = StReq;
          end
        end
      end

      StReq: begin
        // arvalid is never withdrawn once raised; no timeout in this state.
        if (arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          cnt_d     = 8'd0;
          state_d   = StResp;
        end
      end

      StResp: begin
        // rvalid takes priority over an expiring timeout on the same cycle.
        if (rvalid_i) begin
          rready_d    = 1'b0;
          inst_d      = rdata_i;
          fault_d     = (rresp_i == 2'b00) ? FaultNone : FaultBus;
          ifu_valid_d = 1'b1;
          state_d     = StHold;
        end else if (cnt_q == TimeoutLast) begin
          rready_d    = 1'b0;
          inst_d      = FAULT_INST;
          fault_d     = FaultTimeout;
          ifu_valid_d = 1'b1;
          state_d     = StHold;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StHold: begin
        if (out_xfer) begin
          ifu_valid_d = 1'b0;
          ifu_ready_d = 1'b1;
          fetch_cnt_d = fetch_cnt_q + 32'd1;
          state_d     = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Datapath and handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifu_ready_q <= 1'b1;
      ifu_valid_q <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      araddr_q    <= 32'd0;
      inst_q      <= 32'd0;
      inst_pc_q   <= 32'd0;
      fault_q     <= FaultNone;
      fetch_cnt_q <= 32'd0;
      cnt_q       <= 8'd0;
    end else begin
      ifu_ready_q <= ifu_ready_d;
      ifu_valid_q <= ifu_valid_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      araddr_q    <= araddr_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      fault_q     <= fault_d;
      fetch_cnt_q <= fetch_cnt_d;
      cnt_q       <= cnt_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    ifu_ready_o = ifu_ready_q;
    ifu_valid_o = ifu_valid_q;
    arvalid_o   = arvalid_q;
    rready_o    = rready_q;
    araddr_o    = araddr_q;
    inst_o      = inst_q;
    inst_pc_o   = inst_pc_q;
    fault_o     = fault_q;
    fetch_cnt_o = fetch_cnt_q;
  end

endmodule

// File: tb/tb_ysyx_23060221_ifu.sv
// Directed testbench for ysyx_23060221_ifu. Inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_ysyx_23060221_ifu;

  localparam logic [31:0] Ebreak = 32'h00100073;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        wbu_valid;
  logic        ifu_ready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [1:0]  fault;
  logic        ifu_valid;
  logic        idu_ready;
  logic [31:0] fetch_cnt;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_23060221_ifu #(
    .TIMEOUT   (4),
    .FAULT_INST(Ebreak)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_i       (pc),
    .wbu_valid_i(wbu_valid),
    .ifu_ready_o(ifu_ready),
    .araddr_o   (araddr),
    .arvalid_o  (arvalid),
    .arready_i  (arready),
    .rdata_i    (rdata),
    .rresp_i    (rresp),
    .rvalid_i   (rvalid),
    .rready_o   (rready),
    .inst_o     (inst),
    .inst_pc_o  (inst_pc),
    .fault_o    (fault),
    .ifu_valid_o(ifu_valid),
    .idu_ready_i(idu_ready),
    .fetch_cnt_o(fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Out-transfer from HOLD, then confirm return to IDLE with the new count.
  task automatic deliver(input logic [31:0] want_cnt);
    idu_ready = 1'b1;
    tick();
    idu_ready = 1'b0;
    check("deliver_valid", {31'd0, ifu_valid}, 32'd0);
    check("deliver_ready", {31'd0, ifu_ready}, 32'd1);
    check("deliver_cnt", fetch_cnt, want_cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    pc        = 32'd0;
    wbu_valid = 1'b0;
    arready   = 1'b0;
    rdata     = 32'd0;
    rresp     = 2'b00;
    rvalid    = 1'b0;
    idu_ready = 1'b0;

    // Reset state.
    #12;
    check("rst_ifu_ready", {31'd0, ifu_ready}, 32'd1);
    check("rst_ifu_valid", {31'd0, ifu_valid}, 32'd0);
    check("rst_arvalid", {31'd0, arvalid}, 32'd0);
    check("rst_rready", {31'd0, rready}, 32'd0);
    check("rst_araddr", araddr, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_fault", {30'd0, fault}, 32'd0);
    check("rst_fetch_cnt", fetch_cnt, 32'd0);
    #5 rst = 1'b0;

    // 1: basic fetch, minimum latency.
    pc = 32'h30000000; wbu_valid = 1'b1; arready = 1'b1;
    rvalid = 1'b1; rdata = 32'h00000413; rresp = 2'b00;
    tick();  // in-transfer edge
    wbu_valid = 1'b0;
    check("t1_arvalid", {31'd0, arvalid}, 32'd1);
    check("t1_araddr", araddr, 32'h30000000);
    check("t1_ready_low", {31'd0, ifu_ready}, 32'd0);
    check("t1_valid_early", {31'd0, ifu_valid}, 32'd0);
    tick();
    check("t1_arvalid_drop", {31'd0, arvalid}, 32'd0);
    check("t1_rready", {31'd0, rready}, 32'd1);
    check("t1_valid_early2", {31'd0, ifu_valid}, 32'd0);
    tick();
    check("t1_valid", {31'd0, ifu_valid}, 32'd1);
    check("t1_inst", inst, 32'h00000413);
    check("t1_inst_pc", inst_pc, 32'h30000000);
    check("t1_fault", {30'd0, fault}, 32'd0);
    check("t1_rready_drop", {31'd0, rready}, 32'd0);
    deliver(32'd1);
    arready = 1'b0; rvalid = 1'b0;

    // 2: address backpressure then decode backpressure.
    pc = 32'h30000004; wbu_valid = 1'b1;
    tick();
    wbu_valid = 1'b0;
    check("t2_arvalid_0", {31'd0, arvalid}, 32'd1);
    check("t2_araddr_0", araddr, 32'h30000004);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_arvalid_hold", {31'd0, arvalid}, 32'd1);
      check("t2_araddr_hold", araddr, 32'h30000004);
    end
    arready = 1'b1; rvalid = 1'b1; rdata = 32'h00850513;
    tick();
    arready = 1'b0;
    check("t2_rready", {31'd0, rready}, 32'd1);
    tick();
    rvalid = 1'b0; rdata = 32'h0;
    check("t2_valid", {31'd0, ifu_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_hold_valid", {31'd0, ifu_valid}, 32'd1);
      check("t2_hold_inst", inst, 32'h00850513);
      check("t2_hold_pc", inst_pc, 32'h30000004);
      check("t2_hold_fault", {30'd0, fault}, 32'd0);
      check("t2_hold_cnt", fetch_cnt, 32'd1);
    end
    deliver(32'd2);

    // 3: bus error.
    pc = 32'h3000000C; wbu_valid = 1'b1; arready = 1'b1;
    rvalid = 1'b1; rdata = 32'hDEADBEEF; rresp = 2'b10;
    tick();
    wbu_valid = 1'b0;
    tick();
    tick();
    check("t3_valid", {31'd0, ifu_valid}, 32'd1);
    check("t3_fault", {30'd0, fault}, 32'd1);
    check("t3_inst", inst, 32'hDEADBEEF);
    arready = 1'b0; rvalid = 1'b0; rresp = 2'b00;
    deliver(32'd3);

    // 4: misaligned pc, no bus access.
    pc = 32'h30000002; wbu_valid = 1'b1;
    tick();
    wbu_valid = 1'b0;
    check("t4_valid", {31'd0, ifu_valid}, 32'd1);
    check("t4_arvalid", {31'd0, arvalid}, 32'd0);
    check("t4_inst", inst, Ebreak);
    check("t4_fault", {30'd0, fault}, 32'd2);
    check("t4_inst_pc", inst_pc, 32'h30000002);
    deliver(32'd4);
    check("t4_arvalid_after", {31'd0, arvalid}, 32'd0);

    // 5a: timeout with TIMEOUT=4.
    pc = 32'h30000010; wbu_valid = 1'b1; arready = 1'b1;
    tick();
    wbu_valid = 1'b0;
    tick();
    arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t5_rready_high", {31'd0, rready}, 32'd1);
      check("t5_not_valid", {31'd0, ifu_valid}, 32'd0);
      tick();
    end
    check("t5_rready_low", {31'd0, rready}, 32'd0);
    check("t5_valid", {31'd0, ifu_valid}, 32'd1);
    check("t5_fault", {30'd0, fault}, 32'd3);
    check("t5_inst", inst, Ebreak);
    deliver(32'd5);

    // 5b: rvalid on the final RESP cycle wins over the timeout.
    pc = 32'h30000014; wbu_valid = 1'b1; arready = 1'b1;
    tick();
    wbu_valid = 1'b0;
    tick();
    arready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t5b_rready_high", {31'd0, rready}, 32'd1);
      tick();
    end
    check("t5b_rready_last", {31'd0, rready}, 32'd1);
    rvalid = 1'b1; rdata = 32'h12345678;
    tick();
    rvalid = 1'b0;
    check("t5b_valid", {31'd0, ifu_valid}, 32'd1);
    check("t5b_fault", {30'd0, fault}, 32'd0);
    check("t5b_inst", inst, 32'h12345678);
    deliver(32'd6);

    // 6: asynchronous reset during RESP.
    pc = 32'h30000008; wbu_valid = 1'b1; arready = 1'b1;
    tick();
    wbu_valid = 1'b0;
    tick();
    arready = 1'b0;
    check("t6_in_resp", {31'd0, rready}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_rready", {31'd0, rready}, 32'd0);
    check("t6_rst_arvalid", {31'd0, arvalid}, 32'd0);
    check("t6_rst_valid", {31'd0, ifu_valid}, 32'd0);
    check("t6_rst_ready", {31'd0, ifu_ready}, 32'd1);
    check("t6_rst_cnt", fetch_cnt, 32'd0);
    #3 rst = 1'b0;
    rvalid = 1'b1; rdata = 32'hBAD0BAD0; arready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_stale_valid", {31'd0, ifu_valid}, 32'd0);
      check("t6_stale_ready", {31'd0, ifu_ready}, 32'd1);
    end
    rvalid = 1'b0;
    pc = 32'h30000008; wbu_valid = 1'b1;
    tick();
    wbu_valid = 1'b0;
    check("t6_araddr", araddr, 32'h30000008);
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h00000013;
    tick();
    rvalid = 1'b0;
    check("t6_valid", {31'd0, ifu_valid}, 32'd1);
    check("t6_inst", inst, 32'h00000013);
    check("t6_inst_pc", inst_pc, 32'h30000008);
    deliver(32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060221_ifu.md
Name: ysyx_23060221_ifu

Overview:
- Instruction fetch stage; directly downstream of the write-back stage, which produces the next pc together with WBU_valid.
- Accepts the pc through a valid/ready handshake and issues one 32-bit read on a simple AXI4-Lite-style read channel.
- Presents the instruction, its pc and a fault code to the decode stage through a second valid/ready handshake.
- Only one fetch is in flight at a time (non-pipelined, matching the serial multi-cycle core).

Parameters:
- TIMEOUT, 255, number of cycles waited in RESP for rvalid before declaring a timeout fault (8-bit counter; legal range 1..255).
- FAULT_INST, 32'h00100073, instruction word driven on a misaligned or timeout fault (ebreak, so simulation halts).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- pc  in  32  next pc from write-back stage; valid while WBU_valid=1.
- WBU_valid  in  1  write-back stage offers pc.
- IFU_ready  out  1  fetch stage can accept a pc.
- araddr  out  32  read address.
- arvalid  out  1  read address valid.
- arready  in  1  memory accepts address.
- rdata  in  32  read data.
- rresp  in  2  read response; 00 = OKAY, anything else = error.
- rvalid  in  1  read data valid.
- rready  out  1  fetch stage accepts read data.
- inst  out  32  fetched instruction.
- inst_pc  out  32  pc of inst.
- fault  out  2  00 none, 01 bus error, 10 misaligned, 11 timeout.
- IFU_valid  out  1  inst/inst_pc/fault are valid for decode.
- IDU_ready  in  1  decode accepts instruction.
- fetch_cnt  out  32  number of instructions delivered to decode.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- All outputs are registered.

Reset values:
- state=IDLE, IFU_ready=1, IFU_valid=0, arvalid=0, rready=0.
- araddr=0, inst=0, inst_pc=0, fault=0, fetch_cnt=0, timeout counter=0.

Handshakes:
- In: a transfer occurs on a posedge where WBU_valid & IFU_ready.
- Out: a transfer occurs on a posedge where IFU_valid & IDU_ready.

States:
- IDLE (IFU_ready=1)
  - On the in-transfer: latch pc into inst_pc and clear IFU_ready.
  - If pc[1:0]!=0: inst<=FAULT_INST, fault<=10, go to HOLD (no bus access).
  - Otherwise: araddr<=pc, arvalid<=1, go to REQ.
  - rvalid, rdata and arready are ignored in IDLE.
- REQ (arvalid=1)
  - arvalid and araddr stay stable until arready. No timeout applies here; arvalid is never withdrawn.
  - On arvalid & arready: arvalid<=0, rready<=1, counter<=0, go to RESP.
- RESP (rready=1)
  - On rvalid: rready<=0, inst<=rdata. If rresp==00 then fault<=00, else fault<=01 (inst still equals rdata). Go to HOLD.
  - Else, if the counter has reached TIMEOUT-1: rready<=0, inst<=FAULT_INST, fault<=11, go to HOLD.
  - Else: the counter increments.
  - If rvalid arrives on the same cycle the counter reaches TIMEOUT-1, rvalid wins and no timeout is flagged.
- HOLD (IFU_valid=1)
  - inst, inst_pc and fault are held stable while IDU_ready=0.
  - On the out-transfer: IFU_valid<=0, IFU_ready<=1, fetch_cnt<=fetch_cnt+1 (wraps from 2^32-1 to 0), go to IDLE.

Latency:
- Minimum in-transfer to IFU_valid is 3 cycles (IDLE→REQ→RESP→HOLD), with arready and rvalid each asserted on the first eligible cycle.
- Misaligned pc: 1 cycle.
- At most one out-transfer per in-transfer.
- The earliest next in-transfer is the cycle after the out-transfer, because IFU_ready rises at that edge.

Reset mid-operation:
- Return to IDLE immediately; arvalid and rready drop asynchronously.
- A late rvalid or arready from the aborted access is ignored in IDLE.
- The memory side is responsible for discarding the abandoned transaction.
- fetch_cnt is cleared.

Test Plan:
1. Reset release; WBU_valid=1, pc=32'h30000000; arready=1 same cycle; rvalid=1, rdata=32'h00000413, rresp=00 next cycle -> araddr=32'h30000000 for one cycle; IFU_valid=1 exactly 3 cycles after the in-transfer; inst=32'h00000413, inst_pc=32'h30000000, fault=00; with IDU_ready=1, fetch_cnt becomes 1 and IFU_ready=1 the next cycle.
2. Backpressure: arready held 0 for 5 cycles, then IDU_ready held 0 for 4 cycles with pc=32'h30000004 -> arvalid and araddr stable for 6 cycles; inst/inst_pc/fault unchanged while IFU_valid=1; exactly one fetch_cnt increment.
3. Bus error: rresp=2'b10, rdata=32'hDEADBEEF -> fault=01, inst=32'hDEADBEEF, IFU_valid=1.
4. Misaligned: pc=32'h30000002 -> arvalid never asserted; IFU_valid=1 one cycle after the in-transfer; inst=32'h00100073, fault=10, inst_pc=32'h30000002.
5. Timeout: TIMEOUT=4, rvalid never asserted -> rready high 4 cycles then 0; fault=11, inst=32'h00100073. Repeat with rvalid on the 4th RESP cycle -> fault=00, inst=rdata.
6. Reset mid-RESP: assert rst asynchronously between edges -> arvalid, rready, IFU_valid=0 and IFU_ready=1 before the next edge; rvalid=1 after release produces no IFU_valid; the next fetch of pc=32'h30000008 completes normally with fetch_cnt=1.
